// File: rtl/sum_bcd_display_pkg.sv
// Shared types and constants for the BCD converter and 3-digit seven-segment scanner.
package sum_bcd_display_pkg;

    localparam int BCD_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}, element 0 is digit 0.
    localparam logic [0:9][6:0] SEG_LUT = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nib <= 4'd9) begin
            seg = SEG_LUT[nib];
        end
        return seg;
    endfunction

endpackage

// File: rtl/sum_bcd_display_bin_to_bcd.sv
// Sequential double-dabble converter with start/busy/done handshake.
// state | meaning
// IDLE  | waiting for i_start; o_bcd holds the last result
// CONV  | one add-3/shift iteration per cycle, WIDTH iterations total
module bin_to_bcd
    import sum_bcd_display_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int SW    = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t      state_q;
    logic [SW-1:0]    shift_q;
    logic [SW-1:0]    shift_d;
    logic [CNT_W-1:0] cnt_q;
    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = shift_q[SW-1 -: BCD_W];
        for (int n = 0; n < 3; n++) begin
            if (adj[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
            end
        end
        shift_d = {adj[BCD_W-2:0], shift_q[WIDTH-1:0], 1'b0};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_bcd   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= CONV;
                        o_busy  <= 1'b1;
                        shift_q <= {{BCD_W{1'b0}}, i_value};
                        cnt_q   <= '0;
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Final iteration publishes the freshly shifted BCD field directly.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_bcd   <= shift_d[SW-1 -: BCD_W];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sum_bcd_display.sv
// Result-path display: converts the binary sum to BCD and scans it onto a
// common-anode 3-digit seven-segment display with optional leading-zero blanking.
module sum_bcd_display
    import sum_bcd_display_pkg::*;
#(
    parameter int WIDTH       = 9,
    parameter int REFRESH_DIV = 16000,
    parameter int BLANK_LZ    = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd,
    output logic [6:0]       o_seg,
    output logic [2:0]       o_dig
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [RC_W-1:0] ref_cnt_q;
    logic [1:0]      dig_idx_q;
    logic [3:0]      hund;
    logic [3:0]      tens;
    logic [3:0]      units;
    logic            blank_h;
    logic            blank_t;
    logic            blank_sel;
    logic [3:0]      nib_sel;

    bin_to_bcd #(
        .WIDTH(WIDTH)
    ) u_bin_to_bcd (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_value(i_value),
        .i_start(i_start),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_bcd  (o_bcd)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt_q <= '0;
            dig_idx_q <= 2'd0;
        end else if (ref_cnt_q == RC_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            dig_idx_q <= (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + RC_W'(1);
        end
    end

    assign hund    = o_bcd[11:8];
    assign tens    = o_bcd[7:4];
    assign units   = o_bcd[3:0];
    assign blank_h = (BLANK_LZ != 0) && (hund == 4'd0);
    assign blank_t = blank_h && (tens == 4'd0);

    // A blanked digit keeps its enable asserted; only the segments go dark.
    always_comb begin
        nib_sel   = units;
        blank_sel = 1'b0;
        o_dig     = 3'b110;
        case (dig_idx_q)
            2'd1: begin
                nib_sel   = tens;
                blank_sel = blank_t;
                o_dig     = 3'b101;
            end
            2'd2: begin
                nib_sel   = hund;
                blank_sel = blank_h;
                o_dig     = 3'b011;
            end
            default: begin
                nib_sel   = units;
                blank_sel = 1'b0;
                o_dig     = 3'b110;
            end
        endcase
        o_seg = blank_sel ? SEG_BLANK : seg_decode(nib_sel);
    end

endmodule
